// File: rtl/conv_result_axis_packer_if.sv
// ---------------------------------------------------------------------------
// conv_result_axis_packer_if
// 32-bit AXI4-Stream bundle that carries packed convolution results.
//
// Signals:
//   valid - beat valid (master -> slave)
//   data  - packed results, lane 0 in the low bits (master -> slave)
//   keep  - byte enables of the filled lanes (master -> slave)
//   last  - final beat of a frame (master -> slave)
//   user  - start-of-frame marker, present only with CONV_PACK_SOF_EN
//   ready - downstream accept (slave -> master)
//
// Optional macro: CONV_PACK_SOF_EN adds the 'user' signal.
// ---------------------------------------------------------------------------
interface conv_result_axis_packer_if;
  logic        valid;
  logic [31:0] data;
  logic [3:0]  keep;
  logic        last;
  logic        ready;
`ifdef CONV_PACK_SOF_EN
  logic        user;

  modport master (output valid, output data, output keep, output last,
                  output user, input ready);
  modport slave  (input valid, input data, input keep, input last,
                  input user, output ready);
`else
  modport master (output valid, output data, output keep, output last,
                  input ready);
  modport slave  (input valid, input data, input keep, input last,
                  output ready);
`endif
endinterface

// File: rtl/conv_result_axis_packer.sv
// ---------------------------------------------------------------------------
// conv_result_axis_packer
// Collects narrow per-pixel convolution results (cSum/cReady) and packs
// 32/DATA_WIDTH of them into each 32-bit AXI4-Stream beat. Lane 0 occupies
// the low bits and holds the first result of a word. The final beat of a
// frame carries last=1 and a keep covering only the filled lanes. Beats are
// buffered in a small FIFO so downstream stalls do not lose results.
//
// Ports:
//   axi_clk      - clock, all logic on the rising edge
//   Rst          - asynchronous active-high reset
//   enable       - start a frame (sampled only in IDLE)
//   frame_width  - results per line
//   frame_height - lines per frame
//   cSum         - result value
//   cReady       - cSum valid this cycle (no back-pressure to the source)
//   pack_ready   - FIFO has at least two free entries (throttle hint)
//   m_axis       - AXI4-Stream master (valid/data/keep/last/ready[/user])
//   frame_done   - one-cycle pulse after the last beat is accepted
//   overflow     - sticky, a beat was dropped because the FIFO was full
//
// Optional macro: CONV_PACK_SOF_EN stores a start-of-frame flag per FIFO
// entry and drives it on m_axis.user.
// ---------------------------------------------------------------------------
module conv_result_axis_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    axi_clk,
  input  logic                    Rst,
  input  logic                    enable,
  input  logic [CNT_WIDTH-1:0]    frame_width,
  input  logic [CNT_WIDTH-1:0]    frame_height,
  input  logic [DATA_WIDTH-1:0]   cSum,
  input  logic                    cReady,
  output logic                    pack_ready,
  conv_result_axis_packer_if.master m_axis,
  output logic                    frame_done,
  output logic                    overflow
);

  localparam int LANES  = 32 / DATA_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TOT_W  = 2 * CNT_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [TOT_W-1:0]    w_total;
  logic [TOT_W-1:0]    r_total;
  logic [TOT_W-1:0]    r_resultCnt;
  logic [LANE_W-1:0]   r_laneIdx;
  logic [31:0]         r_asm;
  logic                r_firstBeat;

  logic                w_start;
  logic                w_inRun;
  logic                w_inDrain;
  logic                w_accept;
  logic                w_laneFull;
  logic                w_lastResult;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_wr;
  logic [31:0]         w_beatData;
  logic [3:0]          w_beatKeep;

  logic [31:0]         r_memData [FIFO_DEPTH];
  logic [3:0]          r_memKeep [FIFO_DEPTH];
  logic                r_memLast [FIFO_DEPTH];
`ifdef CONV_PACK_SOF_EN
  logic                r_memUser [FIFO_DEPTH];
`endif
  logic [PTR_W-1:0]    r_wrPtr;
  logic [PTR_W-1:0]    r_rdPtr;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;
  logic                r_frameDone;

  assign w_total = TOT_W'(frame_width) * TOT_W'(frame_height);

  // State register.
  always_ff @(posedge axi_clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. DRAIN only exits when the beat carrying last is
  // popped; if that beat was dropped on overflow the block parks here.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (enable && (w_total != '0)) w_nextState = RUN;
      RUN:     if (w_push && w_lastResult)    w_nextState = DRAIN;
      DRAIN:   if (w_pop && m_axis.last)      w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State decode used by the datapath.
  always_comb begin
    w_start   = 1'b0;
    w_inRun   = 1'b0;
    w_inDrain = 1'b0;
    case (r_state)
      IDLE:    w_start   = enable && (w_total != '0);
      RUN:     w_inRun   = 1'b1;
      DRAIN:   w_inDrain = 1'b1;
      default: w_start   = 1'b0;
    endcase
  end

  assign w_accept     = w_inRun && cReady;
  assign w_laneFull   = (r_laneIdx == LANE_W'(LANES - 1));
  assign w_lastResult = (r_resultCnt == (r_total - TOT_W'(1)));
  assign w_push       = w_accept && (w_laneFull || w_lastResult);

  // Beat as it will look once the current result is merged in. Lanes above
  // the current one are already zero because the assembly register is
  // cleared after every push.
  always_comb begin
    w_beatData = r_asm;
    w_beatData[r_laneIdx*DATA_WIDTH +: DATA_WIDTH] = cSum;
  end

  // A byte is enabled when it lies inside the lanes filled so far.
  always_comb begin
    w_beatKeep = '0;
    for (int b = 0; b < 4; b++) begin
      w_beatKeep[b] = ((b * 8) < ((int'(r_laneIdx) + 1) * DATA_WIDTH));
    end
  end

  // Lane/result counters and the assembly register.
  always_ff @(posedge axi_clk or posedge Rst) begin
    if (Rst) begin
      r_total     <= '0;
      r_resultCnt <= '0;
      r_laneIdx   <= '0;
      r_asm       <= '0;
      r_firstBeat <= 1'b0;
    end else if (w_start) begin
      r_total     <= w_total;
      r_resultCnt <= '0;
      r_laneIdx   <= '0;
      r_asm       <= '0;
      r_firstBeat <= 1'b1;
    end else if (w_accept) begin
      r_resultCnt <= r_resultCnt + TOT_W'(1);
      if (w_push) begin
        r_asm       <= '0;
        r_laneIdx   <= '0;
        r_firstBeat <= 1'b0;
      end else begin
        r_asm     <= w_beatData;
        r_laneIdx <= r_laneIdx + LANE_W'(1);
      end
    end
  end

  // A full FIFO still accepts a write when the head is leaving in the same
  // cycle; otherwise the new beat is lost and overflow latches.
  assign w_pop  = (r_count != '0) && m_axis.ready;
  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);

  // Beat FIFO storage, pointers and occupancy.
  always_ff @(posedge axi_clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_memData[i] <= '0;
        r_memKeep[i] <= '0;
        r_memLast[i] <= 1'b0;
`ifdef CONV_PACK_SOF_EN
        r_memUser[i] <= 1'b0;
`endif
      end
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_memData[r_wrPtr] <= w_beatData;
        r_memKeep[r_wrPtr] <= w_beatKeep;
        r_memLast[r_wrPtr] <= w_lastResult;
`ifdef CONV_PACK_SOF_EN
        r_memUser[r_wrPtr] <= r_firstBeat;
`endif
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Frame completion pulse, registered so it has no path from m_axis.ready.
  always_ff @(posedge axi_clk or posedge Rst) begin
    if (Rst) begin
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_inDrain && w_pop && m_axis.last;
    end
  end

  assign m_axis.valid = (r_count != '0);
  assign m_axis.data  = r_memData[r_rdPtr];
  assign m_axis.keep  = r_memKeep[r_rdPtr];
  assign m_axis.last  = r_memLast[r_rdPtr];
`ifdef CONV_PACK_SOF_EN
  assign m_axis.user  = r_memUser[r_rdPtr];
`endif
  assign pack_ready   = (r_count <= CNT_W'(FIFO_DEPTH - 2));
  assign frame_done   = r_frameDone;
  assign overflow     = r_overflow;

endmodule

// File: doc/conv_result_axis_packer.md
Name: conv_result_axis_packer

Overview:
Output-side stream transmitter for the convolution datapath. It collects the narrow per-pixel results (cSum/cReady) from matrixAccelerator and packs 32/DATA_WIDTH results into each 32-bit AXI4-Stream master beat. It asserts tlast and a partial tkeep at frame end and buffers beats in a small FIFO to absorb downstream backpressure. It mirrors the 32-bit input unpacking of the controller's s_axis port, using the same lane ordering.

Parameters:
DATA_WIDTH, 8, result width; must divide 32; LANES = 32/DATA_WIDTH.
FIFO_DEPTH, 4, beat FIFO entries (power of 2, >=2).
CNT_WIDTH, 16, width of frame dimension inputs.

Ports:
axi_clk  in  1  clock; all logic on rising edge
Rst  in  1  asynchronous, active-high reset
enable  in  1  start frames; sampled only in IDLE
frame_width  in  CNT_WIDTH  results per line
frame_height  in  CNT_WIDTH  lines per frame
cSum  in  DATA_WIDTH  result value
cReady  in  1  cSum valid this cycle (no handshake back)
pack_ready  out  1  1 when FIFO has >=2 free entries (upstream throttle hint)
m_axis_valid  out  1  beat valid
m_axis_data  out  32  packed results
m_axis_ready  in  1  downstream accept
m_axis_last  out  1  final beat of frame
m_axis_keep  out  4  byte enables of filled lanes
frame_done  out  1  one-cycle pulse when last beat is accepted
overflow  out  1  sticky; beat dropped because FIFO was full

Behaviour:
- Reset: all outputs 0, FIFO empty, lane/result counters 0, state IDLE, overflow 0. Reset mid-frame discards partial word and FIFO contents.
- total = frame_width*frame_height, 2*CNT_WIDTH bits, latched on IDLE->RUN.
- IDLE: if enable=1 and total!=0, go to RUN with counters cleared. If total==0, stay in IDLE and produce no output. cReady is ignored.
- RUN: each cReady writes cSum into lane lane_idx of the assembly register. Lane 0 = bits [DATA_WIDTH-1:0], which is the first result. lane_idx and result_cnt then increment.
- A beat is pushed in the same edge when lane_idx==LANES-1 or result_cnt==total-1.
  - Pushed keep covers the filled lanes contiguously from bit 0. Each lane covers DATA_WIDTH/8 bytes.
  - Unfilled lanes are 0.
  - last=1 only on the beat holding result total-1.
  - lane_idx wraps to 0 after the push.
- After pushing the last beat, go to DRAIN. cReady is ignored in DRAIN.
- DRAIN: wait for the last beat to be accepted. Then frame_done pulses and the block returns to IDLE. A still-high enable restarts on the next cycle.
- Deasserting enable mid-frame has no effect; the frame completes.
- Latency: the beat completed by cReady at edge N is visible as m_axis_valid=1 after edge N when the FIFO was empty. There is no combinational path from cReady to m_axis_*.
- AXIS: m_axis_valid = FIFO not empty. The head's data/keep/last are held stable while valid && !ready. A pop occurs on valid && ready.
- FIFO full with a push and no pop: the beat is dropped, overflow is set (sticky until Rst), and counters still advance. Frame framing still completes.
- FIFO full with push and pop in the same cycle: both are performed and overflow is not set.
- pack_ready = (count <= FIFO_DEPTH-2). It is combinational from registered count.

Optional Feature:
CONV_PACK_SOF_EN: when defined, adds output port m_axis_user (1 bit), stored per FIFO entry. It is 1 on the first beat of each frame and 0 otherwise, and reset value is 0. When the macro is undefined, the port and storage are absent and the remaining behaviour is identical.

Test Plan:
- W=4, H=4, cReady every cycle, cSum=0..15, ready=1 -> 4 beats: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. keep=0xF on all beats, last only on beat 4, one frame_done pulse.
- W=3, H=3, cSum=1..9 -> beats 0x04030201, 0x08070605, 0x00000009. Final beat has keep=0x1, last=1.
- Backpressure: W=4, H=4, ready=0 during all 16 results -> 4 beats held, pack_ready=0 after beat 3, overflow=0. Data is unchanged while stalled. Releasing ready drains 4 beats in order.
- Overflow: W=4, H=5 (5 beats), ready=0 -> the 5th beat, which carries last, is dropped and overflow=1. The first 4 beats are output intact, state stays in DRAIN, and frame_done stays 0. Only Rst recovers.
- Full plus simultaneous pop: fill the FIFO, then assert ready on the cycle a 5th beat pushes -> no overflow, 5 beats out in order.
- Rst pulse after 6 of 16 results -> all outputs 0 next cycle. A new frame after reset starts at lane 0 with no stale data. W=0 with enable=1 -> state stays IDLE and m_axis_valid stays 0.
